// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative RV32M/RV64M multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam int unsigned MAX_XLEN = 64;

    // Most-negative two's-complement value for an xlen-bit word, right-aligned.
    function automatic logic [MAX_XLEN-1:0] most_neg(input int unsigned xlen);
        return 64'd1 << (xlen - 1);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on magnitudes.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic              div_mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted_hi;
    logic [XLEN:0] diff;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        acc_next   = '0;
        q_bit      = 1'b0;
        // Multiply: {partial product, remaining multiplier bits}; add when the multiplier LSB is set.
        sum        = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: {partial remainder, remaining dividend bits}; shift in the next dividend bit.
        shifted_hi = acc[2*XLEN-1:XLEN-1];
        diff       = shifted_hi - {1'b0, operand};
        if (div_mode) begin
            q_bit    = ~diff[XLEN];
            acc_next = {(q_bit ? diff[XLEN-1:0] : shifted_hi[XLEN-1:0]), acc[XLEN-2:0], q_bit};
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative M-extension unit: valid/ready front end, FSM, counter and sign fix-up around mdu_step.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic              special_q;
    logic [XLEN-1:0]   special_res_q;
    logic [XLEN-1:0]   result_q;

    mdu_op_e           op_in;
    logic              a_signed, b_signed, in_neg_a, in_neg_b, is_div;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic              accept;

    logic [2*XLEN-1:0] step_acc;
    logic              step_q;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    // Request decode: operand signedness, magnitudes and the cases with a fixed answer.
    always_comb begin
        op_in    = mdu_op_e'(in_op);
        a_signed = op_in inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
        b_signed = op_in inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
        in_neg_a = a_signed & in_a[XLEN-1];
        in_neg_b = b_signed & in_b[XLEN-1];
        mag_a    = in_neg_a ? -in_a : in_a;
        mag_b    = in_neg_b ? -in_b : in_b;
        is_div   = in_op[2];
        div_zero = is_div && (in_b == '0);
        div_ovf  = (op_in inside {MDU_DIV, MDU_REM}) && (in_a == MOST_NEG) && (in_b == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = (op_in inside {MDU_DIV, MDU_DIVU}) ? '1 : in_a;
        end else begin
            special_res = (op_in == MDU_DIV) ? in_a : '0;
        end
        accept = in_valid && (state_q == IDLE) && !flush;
    end

    mdu_step #(.XLEN(XLEN)) u_step (
        .div_mode (state_q == DIV),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // Sign fix-up applied to the final step's accumulator as it is registered.
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -step_acc : step_acc;
        unique case (op_q)
            MDU_MUL:                       fix_res = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:             fix_res = (neg_a_q ^ neg_b_q) ? -step_acc[XLEN-1:0]
                                                                          : step_acc[XLEN-1:0];
            default:                       fix_res = neg_a_q ? -step_acc[2*XLEN-1:XLEN]
                                                             : step_acc[2*XLEN-1:XLEN];
        endcase
        // Divide-by-zero and overflow results do not come out of the iteration when EARLY_OUT=0.
        if (special_q) fix_res = special_res_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (EARLY_OUT && special) ? DONE : (is_div ? DIV : MUL);
            MUL,
            DIV:  if (cnt_q == '0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out_result = result_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: only flops live here (no memory arrays), so all of them are cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= MDU_MUL;
            cnt_q         <= '0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            opnd_q        <= '0;
            acc_q         <= '0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_q      <= '0;
        end else if (flush) begin
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    op_q          <= op_in;
                    neg_a_q       <= in_neg_a;
                    neg_b_q       <= in_neg_b;
                    opnd_q        <= is_div ? mag_b : mag_a;
                    acc_q         <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt_q         <= CW'(XLEN - 1);
                    special_q     <= special;
                    special_res_q <= special_res;
                    if (EARLY_OUT && special) result_q <= special_res;
                end
                MUL, DIV: begin
                    acc_q <= step_acc;
                    if (cnt_q == '0) result_q <= fix_res;
                    else             cnt_q    <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    logic unused_q_bit;
    assign unused_q_bit = step_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (XLEN=32, EARLY_OUT=1) against an arithmetic reference model.
module tb_mdu_iter;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    logic rand_ready, force_ready, rnd_bit;
    assign out_ready = rand_ready ? rnd_bit : force_ready;

    mdu_iter #(.XLEN(XLEN), .EARLY_OUT(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_bit = ($urandom_range(0, 3) != 0);

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   seen     = 0;
    bit   have_cur = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain 64-bit arithmetic following the RISC-V M rules.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb_, ub;
        logic [63:0] ua64, ub64, p;
        logic [31:0] r;
        sa   = longint'($signed(a));
        sb_  = longint'($signed(b));
        ub   = longint'({32'b0, b});
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        r    = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb_);   r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb_);   r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub);    r = p[63:32]; end
            3'd3: begin p = ua64 * ub64;     r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb_);
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa % sb_);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sp;
        sp = (op >= 3'd4 && b == 0) ||
             ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
        return sp ? 1 : XLEN + 1;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard when a result appears, then checks it is held while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen     = 0;
            have_cur = 0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1;
                    check({cur.name, "_result"}, out_result, cur.res);
                    check({cur.name, "_latency"}, cyc - cur.acc_cyc, cur.lat);
                end
            end else if (have_cur) begin
                check({cur.name, "_hold"}, out_result, cur.res);
                check({cur.name, "_in_ready_busy"}, in_ready, 1'b0);
            end
        end else begin
            seen     = 0;
            have_cur = 0;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit push, input string name);
        int waited = 0;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check({name, "_ready_timeout"}, in_ready, 1'b1);
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        if (push) sb.push_back('{exp_res, exp_lat(op, a, b), cyc, name});
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_op    = 3'($urandom_range(0, 7));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, sb.size(), 0);
    endtask

    logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] d_b   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_exp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        bit          ever_valid;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          n;

        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_op       = 3'd0;
        in_a        = '0;
        in_b        = '0;
        rand_ready  = 1'b0;
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready",   in_ready,   1'b1);
        check("reset_out_valid",  out_valid,  1'b0);
        check("reset_out_result", out_result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            issue(d_op[i], d_a[i], d_b[i], d_exp[i], 1'b1, $sformatf("dir%0d", i));
        drain("directed");

        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            issue(op, a, b, model(op, a, b), 1'b1, $sformatf("rand%0d_op%0d", i, op));
        end
        drain("random");
        rand_ready = 1'b0;

        // Backpressure: result held for 5 stalled cycles, then handoff and immediate re-accept.
        force_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, "bp_divu");
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_done", out_valid, 1'b1);
        repeat (5) @(negedge clk);
        force_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready,  1'b1);
        issue(3'd0, 32'd3, 32'd5, 32'd15, 1'b1, "bp_next");
        check("bp_next_accepted", in_ready, 1'b0);
        drain("bp");

        // Flush partway through a divide: back to IDLE, no result ever presented.
        issue(3'd4, 32'h12345678, 32'h00000123, 32'h0, 1'b0, "flush_div");
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready",  in_ready,  1'b1);
        check("flush_out_valid", out_valid, 1'b0);
        ever_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ever_valid = 1;
        end
        check("flush_no_output", ever_valid, 1'b0);

        // Flush wins over a simultaneous accept of an early-out op.
        in_valid = 1'b1;
        in_op    = 3'd5;
        in_a     = 32'd5;
        in_b     = 32'd0;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_accept_out_valid", out_valid, 1'b0);
        check("flush_accept_in_ready",  in_ready,  1'b1);

        // Asynchronous reset in the middle of a multiply.
        issue(3'd1, $urandom, $urandom, 32'h0, 1'b0, "rst_mul");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready",   in_ready,   1'b1);
        check("arst_out_valid",  out_valid,  1'b0);
        check("arst_out_result", out_result, 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, "post_rst_mulhu");
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M/RV64M multiply/divide unit that executes the M-extension ops over multiple cycles.
- Sits beside the combinational integer ALU in the execute stage; the decoder steers funct7[0]=1 ops here.
- Uses a valid/ready handshake so the pipeline can stall on it.
- Generalises the former single-cycle M path: parametrised width, radix-2 multi-cycle datapath, early-out for special cases, flush support.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any operation in flight.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a  in  XLEN  rs1 value.
- in_b  in  XLEN  rs2 value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, out_result=0; counter and internal registers cleared.
- States:
  - IDLE: in_ready=1. On accept (in_valid & in_ready & !flush), latch op, operand signs and operand magnitudes. Go to DONE if a special case applies and EARLY_OUT=1, else to MUL (op<4) or DIV (op>=4). Counter loads XLEN-1.
  - MUL: one shift-add step per cycle on the 2*XLEN-bit product of magnitudes. At counter==0, apply sign fix-up, register the result and go to DONE; otherwise decrement the counter.
  - DIV: one restoring subtract-shift step per cycle on magnitudes. Same counter and exit rule as MUL.
  - DONE: out_valid=1 and out_result held stable. On out_ready, go to IDLE.
- Latency: out_valid rises XLEN+1 cycles after the accept edge for iterative ops, and 1 cycle after for early-out ops.
- in_ready is 0 in MUL, DIV and DONE. There is no accept in the same cycle as result handoff.
- Sign rules:
  - MUL and MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - The product is negated iff the operand signs differ (signed operands only).
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Quotient is negative iff the signs differ; remainder takes the sign of the dividend.
- Special cases:
  - b==0: DIV/DIVU return all-ones; REM/REMU return a.
  - a==most-negative and b==all-ones with DIV: returns a. Same case with REM: returns 0.
  - When EARLY_OUT=0, these still produce the same values, after the full latency.
- flush: forces IDLE on the next edge from any state, drops out_valid, discards the result. Flush has priority over accept and over the out_ready handoff.
- Asynchronous reset mid-operation: immediate return to reset values; no residual output.
- Input ports are ignored outside IDLE; operands are captured only on the accept edge.

Decomposition:
- Package mdu_pkg holds:
  - op encodings MDU_MUL..MDU_REMU (3-bit);
  - state encoding IDLE/MUL/DIV/DONE (2-bit);
  - helper constant for the XLEN-wide most-negative value.
- One sub-module, mdu_step (combinational), performs one radix-2 iteration. Given the accumulator, multiplicand/divisor and a mode bit, it returns the next accumulator and the quotient bit. The FSM, counter, sign fix-up and handshake stay in mdu_iter.

Test Plan (XLEN=32):
- MUL a=7, b=0xFFFFFFFD -> out_result=0xFFFFFFEB, out_valid exactly 33 cycles after accept.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases with EARLY_OUT=1, each with out_valid 1 cycle after accept:
  - DIVU 5/0 -> 0xFFFFFFFF;
  - REM 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
  - REM with the same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_result stable, in_ready=0. Then raise out_ready -> IDLE next cycle, and a new op is accepted the following cycle.
- flush at cycle 10 of a DIV -> IDLE next cycle, out_valid never asserts. Async rst_n low mid-MUL -> outputs return to reset values immediately.
